// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake and data bus of the RV32I decode stage.
//   in_valid/in_ready/in_instr/in_pc      fetch -> decode beat
//   out_valid/out_ready/out_ctrl/out_imm  decode -> execute beat, plus
//   out_pc/out_rs1/out_rs2/out_rd/out_illegal
// Modports: slave = the decode stage itself, master = its environment.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_ctrl;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_imm, out_pc,
           out_rs1, out_rs2, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_imm, out_pc,
           out_rs1, out_rs2, out_rd, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a two-entry (main + skid) buffer.
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   flush  drops every buffered instruction and any same-cycle input beat
//   bus    decode_stage_if.slave (fetch-side and execute-side handshakes)
// Optional feature: define DECODE_MULDIV_EN to accept OP funct7=0x01 (M ext).
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_stage_if.slave bus
);

  localparam int unsigned C_ALUSRC   = 4;
  localparam int unsigned C_REGWRITE = 5;
  localparam int unsigned C_MEMTOREG = 6;
  localparam int unsigned C_MEMWRITE = 7;
  localparam int unsigned C_MEMREAD  = 8;
  localparam int unsigned C_BRANCH   = 9;
  localparam int unsigned C_JALR     = 10;
  localparam int unsigned C_JAL      = 11;
  localparam int unsigned C_BSENSE   = 12;
  localparam int unsigned C_LUI      = 13;
  localparam int unsigned C_AUIPC    = 14;
  localparam int unsigned C_MULDIV   = 15;

  typedef struct packed {
    logic [15:0]     ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  // Buffer occupancy: main only, or main plus skid.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MAIN  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q;
  entry_t dec;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [15:0] ctrl;
  logic [31:0] imm32;
  logic        illegal;
  logic [XLEN-1:0] imm_ext;

  logic accept, drain;
  logic load_main, load_skid, skid_to_main;

  // ---------------------------------------------------------------- decode
  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl    = '0;
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      7'h6F: begin
        ctrl[C_JAL]      = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'h67: begin
        ctrl[C_JALR]     = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      7'h63: begin
        ctrl[C_BRANCH] = 1'b1;
        ctrl[C_BSENSE] = instr[12];
        ctrl[3:0]      = 4'b1000;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'h03: begin
        ctrl[C_MEMREAD]  = 1'b1;
        ctrl[C_MEMTOREG] = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      7'h23: begin
        ctrl[C_MEMWRITE] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'h13: begin
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
        ctrl[3:0]        = {1'b0, funct3};
        imm32 = {{20{instr[31]}}, instr[31:20]};
        if (funct3 == 3'b001 && funct7 != 7'h00)
          illegal = 1'b1;
        if (funct3 == 3'b101) begin
          ctrl[3] = instr[30];
          if (funct7 != 7'h00 && funct7 != 7'h20)
            illegal = 1'b1;
        end
      end
      7'h33: begin
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[3:0]        = {instr[30], funct3};
        if (funct7 == 7'h00) begin
          illegal = 1'b0;
        end else if (funct7 == 7'h20) begin
          illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
`ifdef DECODE_MULDIV_EN
        end else if (funct7 == 7'h01) begin
          ctrl[C_MULDIV] = 1'b1;
          ctrl[3:0]      = {1'b0, funct3};
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      7'h37: begin
        ctrl[C_LUI]      = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
        imm32 = {instr[31:12], 12'b0};
      end
      7'h17: begin
        ctrl[C_AUIPC]    = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
        imm32 = {instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl  = '0;
      imm32 = '0;
    end
  end

  // Sign-extend to XLEN without a zero-width replication when XLEN=32.
  always_comb begin
    imm_ext       = {XLEN{imm32[31]}};
    imm_ext[31:0] = imm32;
  end

  always_comb begin
    dec.ctrl    = ctrl;
    dec.imm     = imm_ext;
    dec.pc      = bus.in_pc;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.illegal = illegal;
  end

  // ------------------------------------------------------------- buffering
  assign bus.in_ready = (state_q != S_FULL);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = (state_q != S_EMPTY) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_d   = S_MAIN;
          end
        end
        S_MAIN: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = S_FULL;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (drain) begin
            skid_to_main = 1'b1;
            state_d      = S_MAIN;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= dec;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= dec;
    end
  end

  assign bus.out_valid   = (state_q != S_EMPTY);
  assign bus.out_ctrl    = main_q.ctrl;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush64;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN)) bus ();
  decode_stage_if #(.XLEN(64))   bus64 ();

  decode_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush64),
    .bus   (bus64.slave)
  );

  typedef struct {
    logic [15:0]     ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic            illegal;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   drained = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decoder: immediates from signed arithmetic on the field values.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    exp_t   e;
    longint simm;
    int     op, f3, f7;
    bit     bad;
    int     c;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    simm = 0; c = 0; bad = 0;
    case (op)
      'h6F: begin
        c = (1 << 11) | (1 << 5);
        simm = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
             + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      'h67: begin
        c = (1 << 10) | (1 << 5);
        simm = (ins[31] ? -64'sd2048 : 64'sd0) + longint'(ins[30:20]);
      end
      'h63: begin
        c = (1 << 9) | (int'(ins[12]) << 12) | 8;
        simm = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
             + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      'h03: begin
        c = (1 << 8) | (1 << 6) | (1 << 5) | (1 << 4);
        simm = (ins[31] ? -64'sd2048 : 64'sd0) + longint'(ins[30:20]);
      end
      'h23: begin
        c = (1 << 7) | (1 << 4);
        simm = (ins[31] ? -64'sd2048 : 64'sd0) + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
      end
      'h13: begin
        c = (1 << 5) | (1 << 4) | f3;
        if (f3 == 5) c = c | (int'(ins[30]) * 8);
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5 && f7 != 0 && f7 != 'h20) bad = 1;
        simm = (ins[31] ? -64'sd2048 : 64'sd0) + longint'(ins[30:20]);
      end
      'h33: begin
        if (f7 == 0) c = (1 << 5) | f3;
        else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) c = (1 << 5) | 8 | f3;
`ifdef DECODE_MULDIV_EN
        else if (f7 == 1) c = (1 << 15) | (1 << 5) | f3;
`endif
        else bad = 1;
      end
      'h37, 'h17: begin
        c = ((op == 'h37) ? (1 << 13) : (1 << 14)) | (1 << 5) | (1 << 4);
        simm = longint'($signed(ins & 32'hFFFFF000));
      end
      default: bad = 1;
    endcase
    if (bad) begin c = 0; simm = 0; end
    e.ctrl = c[15:0];
    e.imm = simm[XLEN-1:0];
    e.pc = pc;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.illegal = bad;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: r[6:0] = 7'h6F; 1: r[6:0] = 7'h67; 2: r[6:0] = 7'h63;
      3: r[6:0] = 7'h03; 4: r[6:0] = 7'h23; 5: r[6:0] = 7'h13;
      6: r[6:0] = 7'h33; 7: r[6:0] = 7'h37; 8: r[6:0] = 7'h17;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00; 1: r[31:25] = 7'h20; 2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  // Compare the head against the model at the negedge, then advance the model.
  task automatic cycle();
    int n;
    @(negedge clk);
    n = q.size();
    chk("out_valid", 64'(bus.out_valid), 64'(n > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(n < 2));
    if (n > 0) begin
      chk("out_ctrl", 64'(bus.out_ctrl), 64'(q[0].ctrl));
      chk("out_imm", 64'(bus.out_imm), 64'(q[0].imm));
      chk("out_pc", 64'(bus.out_pc), 64'(q[0].pc));
      chk("out_rs1", 64'(bus.out_rs1), 64'(q[0].rs1));
      chk("out_rs2", 64'(bus.out_rs2), 64'(q[0].rs2));
      chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
      chk("out_illegal", 64'(bus.out_illegal), 64'(q[0].illegal));
    end
    if (flush) begin
      q.delete();
    end else begin
      if (n > 0 && bus.out_ready) begin
        void'(q.pop_front());
        drained++;
      end
      if (bus.in_valid && n < 2) q.push_back(ref_decode(bus.in_instr, bus.in_pc));
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] list4 [4];
  int idx;
  int n0;

  initial begin
    rst = 1'b1; flush = 1'b0; flush64 = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_out_regs", 64'({bus.out_rs1, bus.out_rs2, bus.out_rd}), 64'd0);
    chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADDI x1,x0,-5 with out_ready=1.
    bus.in_valid = 1'b1; bus.in_instr = 32'hFFB00093; bus.in_pc = 32'h100; bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("addi_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_ctrl", 64'(bus.out_ctrl), 64'h0030);
    chk("addi_imm", 64'(bus.out_imm), 64'hFFFFFFFB);
    chk("addi_rd", 64'(bus.out_rd), 64'd1);
    chk("addi_illegal", 64'(bus.out_illegal), 64'd0);
    cycle();

    // LUI on the XLEN=64 instance.
    bus64.in_valid = 1'b1; bus64.in_instr = 32'h12345137; bus64.in_pc = 64'h8000_0000_0000_0000;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    chk("lui64_valid", 64'(bus64.out_valid), 64'd1);
    chk("lui64_imm", bus64.out_imm, 64'h0000000012345000);
    chk("lui64_ctrl", 64'(bus64.out_ctrl), 64'h2030);
    chk("lui64_pc", bus64.out_pc, 64'h8000_0000_0000_0000);
    @(posedge clk); #1;

    // MUL: legality depends on the muldiv build option.
    bus.in_valid = 1'b1; bus.in_instr = 32'h02208033; bus.in_pc = 32'h200;
    cycle();
    bus.in_valid = 1'b0;
`ifdef DECODE_MULDIV_EN
    chk("mul_illegal", 64'(bus.out_illegal), 64'd0);
    chk("mul_muldiv_regwrite", 64'({bus.out_ctrl[15], bus.out_ctrl[5]}), 64'd3);
`else
    chk("mul_illegal", 64'(bus.out_illegal), 64'd1);
    chk("mul_ctrl", 64'(bus.out_ctrl), 64'd0);
`endif
    cycle();

    // Four-instruction stream with three cycles of backpressure.
    list4[0] = 32'h00500113; list4[1] = 32'h402081B3;
    list4[2] = 32'h00412023; list4[3] = 32'hFE208EE3;
    idx = 0; drained = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid  = (idx < 4);
      bus.in_instr  = list4[idx % 4];
      bus.in_pc     = 32'h1000 + 32'(idx) * 4;
      bus.out_ready = (c >= 3);
      n0 = q.size();
      cycle();
      if (c == 1) chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      if (bus.in_valid && n0 < 2) idx++;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_drained", 64'(drained), 64'd4);

    // Flush with two buffered and a third presented.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = gen_instr(); bus.in_pc = 32'h3000 + 32'(k) * 4;
      cycle();
    end
    bus.in_instr = 32'h00100093; flush = 1'b1;
    cycle();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = gen_instr();
      bus.in_pc     = $urandom;
      bus.out_ready = ($urandom_range(0, 4) < 3);
      flush         = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset with a valid output.
    bus.in_valid = 1'b1; bus.in_instr = 32'h00A00513; bus.out_ready = 1'b0;
    cycle();
    bus.in_valid = 1'b0;
    chk("prerst_out_valid", 64'(bus.out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction-decode pipeline stage. It sits between instruction fetch and register read/execute. Each accepted 32-bit instruction is decoded into a control bus, an XLEN-wide sign-extended immediate and register indices, and held behind a valid/ready handshake. A two-entry (main + skid) buffer sustains one instruction per cycle under backpressure and supports a pipeline flush. Compared with the current combinational decoder, it adds U-type, I-type shift and illegal-instruction decode.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64. Sets the width of the immediate and the PC.
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard every buffered instruction and any input beat in the same cycle
- in_valid  input  1  an instruction is presented
- in_ready  output  1  the stage can accept an instruction (registered)
- in_instr  input  32  raw instruction word
- in_pc  input  XLEN  PC of the instruction
- out_valid  output  1  decoded instruction available
- out_ready  input  1  downstream accepts it
- out_ctrl  output  16  control bus (see Operation)
- out_imm  output  XLEN  sign-extended immediate
- out_pc  output  XLEN  PC passed through
- out_rs1, out_rs2, out_rd  output  5 each  instr[19:15], instr[24:20], instr[11:7]
- out_illegal  output  1  the instruction is unsupported

## Operation
- **out_ctrl bit map:**
  - [3:0] alu_op
  - 4 alusrc_imm, 5 regwrite, 6 memtoreg, 7 memwrite, 8 memread
  - 9 branch, 10 jalr, 11 jal, 12 branch_sense (= instr[12])
  - 13 lui, 14 auipc, 15 muldiv
- **Per-opcode decode:**
  - 0x6F JAL: jal, regwrite. J-immediate.
  - 0x67 JALR: jalr, regwrite. I-immediate.
  - 0x63 branch: branch, branch_sense, alu_op=4'b1000. B-immediate.
  - 0x03 load: memread, memtoreg, regwrite, alusrc_imm, alu_op=0. I-immediate.
  - 0x23 store: memwrite, alusrc_imm, alu_op=0. S-immediate.
  - 0x13 OP-IMM: regwrite, alusrc_imm, alu_op={0,funct3}. For funct3=101, alu_op[3]=instr[30]. I-immediate.
  - 0x33 OP: regwrite, alu_op={instr[30],funct3}. Immediate is 0.
  - 0x37 LUI: lui, regwrite, alusrc_imm. Immediate = {instr[31:12],12'b0}.
  - 0x17 AUIPC: auipc, regwrite, alusrc_imm. Immediate = {instr[31:12],12'b0}.
- **Immediates:** all are sign-extended from their top bit to XLEN.
- **Illegal instructions:**
  - Any opcode not listed above.
  - OP with funct7 other than 0x00 or 0x20.
  - OP with funct7=0x20 and funct3 other than 000 or 101.
  - OP-IMM funct3=001 with instr[31:25]≠0.
  - OP-IMM funct3=101 with instr[31:25] not 0x00 or 0x20.
  - Required result: out_illegal=1, out_ctrl=0, out_imm=0. PC and register fields still pass through, and the beat still obeys the handshake.
- **Buffering:**
  - Decode is combinational on the input side. Decoded results are stored in the main register (drives the outputs) or the skid register.
  - Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready.
  - in_ready = !skid_valid.
  - Accept while the main register is empty or draining: load main.
  - Accept while main is valid and not draining: load skid.
  - Drain while skid is valid: skid moves to main and skid empties. No accept is possible in that cycle.
  - Drain with nothing incoming: out_valid drops.
- **Flush:** the next edge clears main_valid and skid_valid. An input beat accepted in the same cycle is discarded. Flush has priority over all other events.

## Timing
- Reset values: out_valid=0 and in_ready=1. out_ctrl, out_imm, out_pc, out_rs*, out_rd and out_illegal are all 0.
- Latency: an instruction accepted at edge N is presented on the outputs after edge N, for one cycle at minimum.
- Throughput: 1 instruction per cycle while out_ready=1.
- Under backpressure, at most 2 instructions are held. in_ready drops the cycle after the skid fills.
- Outputs stay stable while out_valid && !out_ready.
- Reset asserted mid-operation empties both entries immediately (asynchronous). Reset overrides flush.

## Configuration
- **DECODE_MULDIV_EN defined:** OP with funct7=0x01 is legal. It sets muldiv and regwrite, with alu_op={0,funct3}.
- **Not defined:** funct7=0x01 is illegal and muldiv is always 0.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093), out_ready=1: one cycle later out_ctrl=0x0030, out_imm=0xFFFFFFFB, out_rd=1, out_illegal=0.
- LUI x2,0x12345 (0x12345137) with XLEN=64: out_imm=0x0000000012345000, and bits lui, regwrite, alusrc_imm are set.
- Stream of 4 instructions, holding out_ready=0 for 3 cycles: in_ready falls after the second accept. The outputs hold instruction 1. On release, the order is 1, 2, 3, 4 with no loss or duplication.
- Flush asserted while 2 instructions are buffered and a third is presented: the next cycle has out_valid=0 and in_ready=1. None of the three appear at the output.
- MUL (0x02208033): illegal with out_ctrl=0 when DECODE_MULDIV_EN is undefined. When defined, muldiv=1, regwrite=1 and out_illegal=0.
- Reset asserted while out_valid=1: out_valid=0 immediately, without waiting for a clock edge.
